// File: rtl/fib_bcd_if.sv
// fib_bcd_if: start/done handshake plus data buses between a producer (e.g. fib)
// and the fib_bcd binary-to-BCD converter.
//   start  master->slave  request conversion (sampled only while slave is idle)
//   bin    master->slave  binary value, captured on the edge that accepts start
//   busy   slave->master  conversion in progress, through the done cycle
//   done   slave->master  one-cycle pulse, bcd holds the new result
//   bcd    slave->master  packed BCD, digit 0 in [3:0]
interface fib_bcd_if #(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 7
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/fib_bcd.sv
// fib_bcd: sequential double-dabble (shift-add-3) converter, one input bit per
// clock. Downstream stage of fib; shares its start/done handshake so fib's
// done/result can drive start/bin directly.
//   clk  in   clock, rising edge
//   rst  in   asynchronous reset, active-low
//   bus  slave modport of fib_bcd_if (start, bin, busy, done, bcd)
// Latency: start accepted at edge k, done and bcd valid after edge k+BIN_W+1.
module fib_bcd #(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 7
) (
  input  logic     clk,
  input  logic     rst,
  fib_bcd_if.slave bus
);

  function automatic longint unsigned pow10(int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MAXBIN = (longint'(1) << BIN_W) - 1;
  localparam int unsigned     CNT_W  = $clog2(BIN_W + 1);

  if (pow10(DIGITS) <= MAXBIN) begin : g_digits_check
    $error("fib_bcd: DIGITS too small to hold 2**BIN_W-1");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_nxt;
  logic [BIN_W-1:0]    shift_q;
  logic [4*DIGITS-1:0] scratch_q;
  logic [4*DIGITS-1:0] adj;
  logic [CNT_W-1:0]    cnt_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                done_q;
  logic                busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction applied to every digit before the shift.
  always_comb begin
    adj = scratch_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  // Outputs are registered one edge behind the state, so done/busy appear on
  // the edge leaving DONE and busy covers that done cycle while the FSM is
  // already back in IDLE (allowing a start in the done cycle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state != IDLE);
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            shift_q   <= bus.bin;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          {scratch_q, shift_q} <= {adj, shift_q} << 1;
          cnt_q                <= cnt_q - CNT_W'(1);
        end
        DONE: begin
          bcd_q  <= scratch_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.bcd  = bcd_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_fib_bcd.sv
module tb_fib_bcd;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fib_bcd_if #(.BIN_W(20), .DIGITS(7)) bus ();

  fib_bcd #(.BIN_W(20), .DIGITS(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned fib_ref(int unsigned n);
    int unsigned a, b, t;
    a = 0; b = 1;
    for (int unsigned i = 0; i < n; i++) begin
      t = a + b; a = b; b = t;
    end
    return a;
  endfunction

  function automatic logic [27:0] to_bcd(int unsigned v);
    logic [27:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < 7; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Stimulus: issue start with value v, then randomise bin after acceptance.
  // Returns edges from acceptance to done (100 = timed out) and the bcd seen.
  task automatic convert(input logic [19:0] v, input bit immediate,
                         output int lat, output logic [27:0] res);
    if (!immediate) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = v;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bin   = 20'($urandom);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.bcd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.bin = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.bcd} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b bcd=%h, required 0/0/0000000",
               bus.busy, bus.done, bus.bcd);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_zero();
    int lat;
    logic [27:0] res;
    convert(20'd0, 1'b0, lat, res);
    checks++;
    if (lat !== 21) begin
      errors++;
      $display("FAIL zero_latency: got %0d cycles, required 21", lat);
    end
    checks++;
    if (res !== 28'h0000000) begin
      errors++;
      $display("FAIL zero_bcd: got %h, required 0000000", res);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_done_cycle: got %b, required 1", bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b, required 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_fib_values();
    int lat;
    logic [27:0] res;
    convert(20'd6765, 1'b0, lat, res);
    checks++;
    if (lat !== 21 || res !== 28'h0006765) begin
      errors++;
      $display("FAIL fib20: lat=%0d bcd=%h, required 21/0006765", lat, res);
    end
    convert(20'd832040, 1'b0, lat, res);
    checks++;
    if (lat !== 21 || res !== 28'h0832040) begin
      errors++;
      $display("FAIL fib30: lat=%0d bcd=%h, required 21/0832040", lat, res);
    end
  endtask

  task automatic test_max();
    int lat;
    logic [27:0] res;
    convert(20'hFFFFF, 1'b0, lat, res);
    checks++;
    if (lat !== 21 || res !== 28'h1048575) begin
      errors++;
      $display("FAIL max_value: lat=%0d bcd=%h, required 21/1048575", lat, res);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (res[4*i +: 4] > 4'd9) begin
        errors++;
        $display("FAIL max_nibble%0d: got %h, required <= 9", i, res[4*i +: 4]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int ndone, first_at;
    logic [27:0] first_bcd;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 20'd55;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_conv: got %b, required 1", bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 20'd99;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bin   = '0;
    ndone = 0; first_at = 0; first_bcd = '0;
    for (int e = 6; e <= 50; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          first_at  = e;
          first_bcd = bus.bcd;
        end
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL busy_start_done_count: got %0d, required 1", ndone);
    end
    checks++;
    if (first_bcd !== 28'h0000055 || first_at !== 21) begin
      errors++;
      $display("FAIL busy_start_result: bcd=%h at %0d, required 0000055 at 21",
               first_bcd, first_at);
    end
  endtask

  task automatic test_reset_abort();
    int lat, seen;
    logic [27:0] res;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 20'd12345;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.bcd} !== 30'd0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b done=%b bcd=%h, required 0/0/0000000",
               bus.busy, bus.done, bus.bcd);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d pulses, required 0", seen);
    end
    convert(20'd12345, 1'b0, lat, res);
    checks++;
    if (lat !== 21 || res !== 28'h0012345) begin
      errors++;
      $display("FAIL after_reset_conv: lat=%0d bcd=%h, required 21/0012345", lat, res);
    end
  endtask

  // Chained like fib: each new start is raised in the done cycle of the
  // previous conversion, giving one conversion every 22 cycles.
  task automatic test_back_to_back();
    int lat;
    int unsigned idx, f;
    logic [27:0] res;
    for (int n = 0; n < 10; n++) begin
      idx = $urandom_range(29, 0);
      f   = fib_ref(idx);
      convert(20'(f), (n != 0), lat, res);
      checks++;
      if (lat !== 21 || res !== to_bcd(f)) begin
        errors++;
        $display("FAIL chain_fib%0d: lat=%0d bcd=%h, required 21/%h (%0d)",
                 idx, lat, res, to_bcd(f), f);
      end
      if (lat >= 100) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_zero();
    test_fib_values();
    test_max();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
